// File: rtl/fetch_redirect_if.sv
// Redirect/event bundle between WB/CP0, the fetch redirect unit and IF.
// The master side is the redirect unit; the slave side is the surrounding pipeline.
interface fetch_redirect_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   exception_valid;
  logic                   eret_flush;
  logic [31:0]            epc;
  logic [7:0]             interrupt_valid;
  logic                   if_ready;
  logic                   flush;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   interrupt_request;
  logic [COUNT_WIDTH-1:0] redirect_count;

  modport master (
    input  exception_valid, eret_flush, epc, interrupt_valid, if_ready,
    output flush, redirect_valid, redirect_pc, interrupt_request, redirect_count
  );

  modport slave (
    output exception_valid, eret_flush, epc, interrupt_valid, if_ready,
    input  flush, redirect_valid, redirect_pc, interrupt_request, redirect_count
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: converts WB exception/ERET commits into a one-cycle flush plus
// a held PC redirect to IF (valid/ready), issues the boot redirect after reset, and
// registers the CP0 pending-interrupt summary as an interrupt request for ID.
// Optional build macro: IRQ_FILTER_EN -- interrupt_request requires pending interrupts
// in two consecutive eligible cycles instead of one.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC         = 32'hbfc00000,
  parameter logic [31:0] EXCEPTION_VECTOR = 32'hbfc00380,
  parameter int          COUNT_WIDTH      = 16
) (
  input  logic              clock,
  input  logic              reset,
  fetch_redirect_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    IDLE    = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic                   flush_reg, flush_next;
  logic                   redirect_valid_reg, redirect_valid_next;
  logic [31:0]            redirect_pc_reg, redirect_pc_next;
  logic                   interrupt_request_reg, interrupt_request_next;
  logic [COUNT_WIDTH-1:0] redirect_count_reg, redirect_count_next;
  // Marks that the redirect currently held is the boot redirect (not counted).
  logic                   boot_redirect_reg, boot_redirect_next;
`ifdef IRQ_FILTER_EN
  // First qualifying cycle seen; a second consecutive one raises the request.
  logic                   irq_qualified_reg, irq_qualified_next;
`endif

  logic        event_present;
  logic [31:0] event_target;
  logic        handshake;
  logic        irq_eligible;

  // Event decode: exception wins over ERET when both commit together.
  always_comb begin
    event_present = bus.exception_valid | bus.eret_flush;
    event_target  = bus.exception_valid ? EXCEPTION_VECTOR : bus.epc;
    handshake     = redirect_valid_reg & bus.if_ready;
    irq_eligible  = (|bus.interrupt_valid) && (state_reg == IDLE) && !event_present;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_next          = state_reg;
    flush_next          = 1'b0;
    redirect_valid_next = redirect_valid_reg;
    redirect_pc_next    = redirect_pc_reg;
    redirect_count_next = redirect_count_reg;
    boot_redirect_next  = boot_redirect_reg;

    case (state_reg)
      BOOT: begin
        state_next          = PENDING;
        redirect_valid_next = 1'b1;
        redirect_pc_next    = RESET_PC;
        boot_redirect_next  = 1'b1;
      end
      IDLE: begin
        if (event_present) begin
          state_next          = PENDING;
          flush_next          = 1'b1;
          redirect_valid_next = 1'b1;
          redirect_pc_next    = event_target;
          boot_redirect_next  = 1'b0;
        end
      end
      PENDING: begin
        // An accepted event redirect counts even if a new event replaces it this cycle.
        if (handshake && !boot_redirect_reg) begin
          redirect_count_next = redirect_count_reg + COUNT_WIDTH'(1);
        end
        if (event_present) begin
          flush_next          = 1'b1;
          redirect_valid_next = 1'b1;
          redirect_pc_next    = event_target;
          boot_redirect_next  = 1'b0;
        end else if (handshake) begin
          state_next          = IDLE;
          redirect_valid_next = 1'b0;
          boot_redirect_next  = 1'b0;
        end
      end
      default: begin
        state_next          = BOOT;
        redirect_valid_next = 1'b0;
      end
    endcase

`ifdef IRQ_FILTER_EN
    irq_qualified_next     = irq_eligible;
    interrupt_request_next = irq_eligible & irq_qualified_reg;
`else
    interrupt_request_next = irq_eligible;
`endif
  end

  // State and output registers with synchronous reset back to the boot sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg             <= BOOT;
      flush_reg             <= 1'b0;
      redirect_valid_reg    <= 1'b0;
      redirect_pc_reg       <= RESET_PC;
      interrupt_request_reg <= 1'b0;
      redirect_count_reg    <= '0;
      boot_redirect_reg     <= 1'b0;
`ifdef IRQ_FILTER_EN
      irq_qualified_reg     <= 1'b0;
`endif
    end else begin
      state_reg             <= state_next;
      flush_reg             <= flush_next;
      redirect_valid_reg    <= redirect_valid_next;
      redirect_pc_reg       <= redirect_pc_next;
      interrupt_request_reg <= interrupt_request_next;
      redirect_count_reg    <= redirect_count_next;
      boot_redirect_reg     <= boot_redirect_next;
`ifdef IRQ_FILTER_EN
      irq_qualified_reg     <= irq_qualified_next;
`endif
    end
  end

  assign bus.flush             = flush_reg;
  assign bus.redirect_valid    = redirect_valid_reg;
  assign bus.redirect_pc       = redirect_pc_reg;
  assign bus.interrupt_request = interrupt_request_reg;
  assign bus.redirect_count    = redirect_count_reg;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Testbench for fetch_redirect_unit: expected redirect targets are queued when events
// are driven and checked when IF accepts them; counts and pulses are checked inline.
module tb_fetch_redirect_unit;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_VEC  = 32'hbfc00380;
`ifdef IRQ_FILTER_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  fetch_redirect_if #(.COUNT_WIDTH(16)) bus ();

  fetch_redirect_unit #(
    .RESET_PC(RESET_PC), .EXCEPTION_VECTOR(EXC_VEC), .COUNT_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_count = '0;
  bit          boot_outstanding = 1'b0;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // IF accepts the held redirect; the scoreboard supplies the target it must carry.
  task automatic accept(input string name);
    logic [31:0] want;
    chk({name, ".valid_before"}, 32'(bus.redirect_valid), 32'd1);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s.scoreboard: got=empty want=entry", name);
    end else begin
      want = exp_q.pop_front();
      total--;
      chk({name, ".pc"}, bus.redirect_pc, want);
    end
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    if (!boot_outstanding) exp_count++;
    boot_outstanding = 1'b0;
    chk({name, ".valid_after"}, 32'(bus.redirect_valid), 32'd0);
    chk({name, ".count"}, 32'(bus.redirect_count), 32'(exp_count));
  endtask

  // Drive one event pulse from IDLE and check the flush/redirect it produces.
  task automatic event_pulse(input string name, input logic exc, input logic eret,
                             input logic [31:0] epc_val);
    bus.exception_valid = exc;
    bus.eret_flush      = eret;
    bus.epc             = epc_val;
    exp_q.push_back(exc ? EXC_VEC : epc_val);
    tick();
    bus.exception_valid = 1'b0;
    bus.eret_flush      = 1'b0;
    bus.epc             = 32'h0;
    chk({name, ".flush"}, 32'(bus.flush), 32'd1);
    chk({name, ".valid"}, 32'(bus.redirect_valid), 32'd1);
    chk({name, ".pc"}, bus.redirect_pc, exc ? EXC_VEC : epc_val);
    tick();
    chk({name, ".flush_one_cycle"}, 32'(bus.flush), 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("reset.valid", 32'(bus.redirect_valid), 32'd0);
    chk("reset.pc", bus.redirect_pc, RESET_PC);
    chk("reset.flush", 32'(bus.flush), 32'd0);
    chk("reset.irq", 32'(bus.interrupt_request), 32'd0);
    chk("reset.count", 32'(bus.redirect_count), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_count = '0;
    exp_q.push_back(RESET_PC);
    boot_outstanding = 1'b1;
    tick();
    chk("boot.valid", 32'(bus.redirect_valid), 32'd1);
    chk("boot.pc", bus.redirect_pc, RESET_PC);
    chk("boot.flush", 32'(bus.flush), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("boot.hold_valid", 32'(bus.redirect_valid), 32'd1);
      chk("boot.hold_pc", bus.redirect_pc, RESET_PC);
      chk("boot.hold_flush", 32'(bus.flush), 32'd0);
    end
    accept("boot.accept");
  endtask

  task automatic test_exception();
    event_pulse("exc", 1'b1, 1'b0, 32'h0);
    accept("exc.accept");
  endtask

  task automatic test_eret();
    event_pulse("eret", 1'b0, 1'b1, 32'h80001234);
    accept("eret.accept");
    event_pulse("both", 1'b1, 1'b1, 32'h80004444);
    accept("both.accept");
  endtask

  // New events while PENDING: without and with a simultaneous handshake.
  task automatic test_override();
    event_pulse("ovr1", 1'b0, 1'b1, 32'h80002000);
    // Replaced before acceptance: the old target is dropped and never counts.
    void'(exp_q.pop_back());
    bus.eret_flush = 1'b1;
    bus.epc        = 32'h80003000;
    exp_q.push_back(32'h80003000);
    tick();
    bus.eret_flush = 1'b0;
    chk("ovr1.flush", 32'(bus.flush), 32'd1);
    chk("ovr1.pc", bus.redirect_pc, 32'h80003000);
    chk("ovr1.count", 32'(bus.redirect_count), 32'(exp_count));
    // Exception in the handshake cycle: old target counts, new one replaces it.
    chk("ovr2.old_pc", bus.redirect_pc, exp_q.pop_front());
    bus.if_ready        = 1'b1;
    bus.exception_valid = 1'b1;
    exp_q.push_back(EXC_VEC);
    tick();
    bus.if_ready        = 1'b0;
    bus.exception_valid = 1'b0;
    exp_count++;
    chk("ovr2.flush", 32'(bus.flush), 32'd1);
    chk("ovr2.valid", 32'(bus.redirect_valid), 32'd1);
    chk("ovr2.pc", bus.redirect_pc, EXC_VEC);
    chk("ovr2.count", 32'(bus.redirect_count), 32'(exp_count));
    tick();
    chk("ovr2.flush_one_cycle", 32'(bus.flush), 32'd0);
    accept("ovr2.accept");
  endtask

  task automatic test_interrupt();
    bus.interrupt_valid = 8'h04;
    for (int i = 1; i < IRQ_LAT; i++) begin
      tick();
      chk("irq.qualifying", 32'(bus.interrupt_request), 32'd0);
    end
    tick();
    chk("irq.set", 32'(bus.interrupt_request), 32'd1);
    event_pulse("irq.event", 1'b1, 1'b0, 32'h0);
    chk("irq.pending0", 32'(bus.interrupt_request), 32'd0);
    tick();
    chk("irq.pending1", 32'(bus.interrupt_request), 32'd0);
    accept("irq.accept");
    chk("irq.after_accept", 32'(bus.interrupt_request), 32'd0);
    for (int i = 1; i < IRQ_LAT; i++) begin
      tick();
      chk("irq.requalifying", 32'(bus.interrupt_request), 32'd0);
    end
    tick();
    chk("irq.reset_idle", 32'(bus.interrupt_request), 32'd1);
    bus.interrupt_valid = 8'h00;
    tick();
    chk("irq.cleared", 32'(bus.interrupt_request), 32'd0);
  endtask

  // Back-to-back accepted overrides drive the counter to all-ones, then it wraps.
  task automatic test_wrap();
    int k;
    event_pulse("wrap.start", 1'b1, 1'b0, 32'h0);
    k = 65535 - int'(exp_count);
    bus.exception_valid = 1'b1;
    bus.if_ready        = 1'b1;
    for (int i = 0; i < k; i++) tick();
    bus.exception_valid = 1'b0;
    exp_count = 16'hffff;
    chk("wrap.preload", 32'(bus.redirect_count), 32'h0000ffff);
    tick();
    bus.if_ready = 1'b0;
    exp_count++;
    chk("wrap.zero", 32'(bus.redirect_count), 32'(exp_count));
    chk("wrap.valid", 32'(bus.redirect_valid), 32'd0);
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    event_pulse("mid.event", 0, 1'b1, 32'h80007777);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid.valid", 32'(bus.redirect_valid), 32'd0);
    chk("mid.pc", bus.redirect_pc, RESET_PC);
    chk("mid.count", 32'(bus.redirect_count), 32'd0);
    chk("mid.flush", 32'(bus.flush), 32'd0);
    exp_q.delete();
    exp_count = '0;
    exp_q.push_back(RESET_PC);
    boot_outstanding = 1'b1;
    tick();
    chk("mid.boot_valid", 32'(bus.redirect_valid), 32'd1);
    chk("mid.boot_pc", bus.redirect_pc, RESET_PC);
    accept("mid.boot_accept");
  endtask

  initial begin
    bus.exception_valid = 1'b0;
    bus.eret_flush      = 1'b0;
    bus.epc             = 32'h0;
    bus.interrupt_valid = 8'h00;
    bus.if_ready        = 1'b0;
    test_reset();
    test_exception();
    test_eret();
    test_override();
    test_interrupt();
    test_wrap();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard.leftover: got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
